// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and default bit period.
package uart_pkg;

  localparam int unsigned DATA_BITS        = 8;
  localparam int unsigned CLKS_PER_BIT_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for asynchronous inputs; resets to 1 (idle level of a serial line).
module uart_rx_sync (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with framing-error detection.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop bits.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  import uart_pkg::*;

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  rx_state_t              r_state;
  logic [CW-1:0]          r_clk_cnt;
  logic [2:0]             r_bit_idx;
  logic [DATA_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]   r_data_out;
  logic                   r_data_valid;
  logic                   r_frame_err;
  logic                   r_parity_err;
  logic                   w_rx_s;
  logic                   w_par_ok;

  uart_rx_sync u_sync (
    .i_clock (clock),
    .i_reset (reset),
    .i_d     (rx),
    .o_q     (w_rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic r_par;
  assign w_par_ok = ~(^r_shift ^ r_par);
`else
  assign w_par_ok = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_clk_cnt    <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par        <= 1'b0;
`endif
    end else begin
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_clk_cnt <= '0;
          if (!w_rx_s) r_state <= ST_START;
        end
        ST_START: begin
          if (r_clk_cnt == CNT_HALF) begin
            r_clk_cnt <= '0;
            if (!w_rx_s) begin
              r_state   <= ST_DATA;
              r_bit_idx <= '0;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (r_clk_cnt == CNT_LAST) begin
            r_clk_cnt          <= '0;
            r_shift[r_bit_idx] <= w_rx_s;
            if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= ST_PARITY;
`else
              r_state <= ST_STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (r_clk_cnt == CNT_LAST) begin
            r_clk_cnt <= '0;
            r_par     <= w_rx_s;
            r_state   <= ST_STOP;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (r_clk_cnt == CNT_LAST) begin
            r_clk_cnt <= '0;
            // Framing error outranks a parity mismatch; either way data_out holds.
            if (w_rx_s) begin
              r_state <= ST_IDLE;
              if (w_par_ok) begin
                r_data_out   <= r_shift;
                r_data_valid <= 1'b1;
              end else begin
                r_parity_err <= 1'b1;
              end
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= ST_BREAK;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        ST_BREAK: begin
          if (w_rx_s) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are driven bit by bit and checked against
// expectations derived from the frame contents and the fixed receive latency.
module tb_uart_rx;

  localparam int C = 8;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int LAT = C / 2 + (NBITS - 1) * C + 3;

  localparam int K_DV = 1;
  localparam int K_FE = 2;
  localparam int K_PE = 3;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int   cyc;
  int   checks;
  int   errors;
  int   overlaps;
  ev_t  evq[$];
  logic [7:0] last_good;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clock      (clk),
    .reset      (reset),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: logs every pulse with the cycle it was seen.
  initial overlaps = 0;
  always @(negedge clk) begin
    if (int'(data_valid) + int'(frame_err) + int'(parity_err) > 1) overlaps = overlaps + 1;
    if (data_valid) evq.push_back('{K_DV, data_out, cyc});
    if (frame_err)  evq.push_back('{K_FE, data_out, cyc});
    if (parity_err) evq.push_back('{K_PE, data_out, cyc});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(C);
  endtask

  // Drives one whole frame; returns the cycle index at which rx fell.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b,
                            output int t_fall);
    t_fall = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par_b);
`else
    if (par_b) begin end
`endif
    send_bit(stop_b);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    rx    = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
    checks += 5;
    if (data_out !== 8'h00)   begin errors++; $display("FAIL reset_data_out: got %h want 00", data_out); end
    if (data_valid !== 1'b0)  begin errors++; $display("FAIL reset_data_valid: got %b want 0", data_valid); end
    if (frame_err !== 1'b0)   begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    if (parity_err !== 1'b0)  begin errors++; $display("FAIL reset_parity_err: got %b want 0", parity_err); end
    if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    last_good = 8'h00;
  endtask

  // Good frames: 0xA5 first, then random bytes with random idle gaps.
  task automatic test_good_frames(input int n);
    int t;
    logic [7:0] d;
    for (int k = 0; k < n; k++) begin
      d = (k == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
      evq.delete();
      send_frame(d, 1'b1, ^d, t);
      checks += 6;
      if (busy !== 1'b0) begin errors++; $display("FAIL good_busy_after: byte %h got %b want 0", d, busy); end
      tick(2);
      if (evq.size() != 1) begin
        errors++; $display("FAIL good_count: byte %h got %0d strobes want 1", d, evq.size());
      end else begin
        if (evq[0].kind != K_DV) begin errors++; $display("FAIL good_kind: byte %h got %0d want %0d", d, evq[0].kind, K_DV); end
        if (evq[0].data !== d)   begin errors++; $display("FAIL good_data: got %h want %h", evq[0].data, d); end
        if (evq[0].cyc != t + LAT) begin errors++; $display("FAIL good_latency: got %0d want %0d", evq[0].cyc - t, LAT); end
      end
      if (data_out !== d) begin errors++; $display("FAIL good_hold: got %h want %h", data_out, d); end
      if (busy !== 1'b0)  begin errors++; $display("FAIL good_idle: got %b want 0", busy); end
      last_good = d;
      tick($urandom_range(0, 3 * C));
    end
  endtask

  task automatic test_glitch;
    evq.delete();
    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    tick(2);
    checks += 3;
    if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_high: got %b want 1", busy); end
    tick(C / 2 + 1);
    if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_low: got %b want 0", busy); end
    tick(2 * C);
    if (evq.size() != 0) begin errors++; $display("FAIL glitch_strobes: got %0d want 0", evq.size()); end
  endtask

  task automatic test_frame_err;
    int t;
    evq.delete();
    send_frame(8'h3C, 1'b0, ^8'h3C, t);
    tick(20 * C - C);
    checks += 5;
    if (evq.size() != 1) begin
      errors++; $display("FAIL ferr_count: got %0d strobes want 1", evq.size());
    end else begin
      if (evq[0].kind != K_FE) begin errors++; $display("FAIL ferr_kind: got %0d want %0d", evq[0].kind, K_FE); end
      if (evq[0].cyc != t + LAT) begin errors++; $display("FAIL ferr_latency: got %0d want %0d", evq[0].cyc - t, LAT); end
    end
    if (data_out !== last_good) begin errors++; $display("FAIL ferr_hold: got %h want %h", data_out, last_good); end
    if (busy !== 1'b1) begin errors++; $display("FAIL ferr_break_busy: got %b want 1", busy); end
    rx = 1'b1;
    tick(3 * C);
    checks += 2;
    if (evq.size() != 1) begin errors++; $display("FAIL ferr_break_quiet: got %0d strobes want 1", evq.size()); end
    if (busy !== 1'b0) begin errors++; $display("FAIL ferr_release: got %b want 0", busy); end
    evq.delete();
    send_frame(8'h5A, 1'b1, ^8'h5A, t);
    tick(2);
    checks += 2;
    if (evq.size() != 1 || evq[0].kind != K_DV) begin
      errors++; $display("FAIL ferr_recover: got %0d strobes want one data_valid", evq.size());
    end
    if (data_out !== 8'h5A) begin errors++; $display("FAIL ferr_recover_data: got %h want 5a", data_out); end
    last_good = 8'h5A;
    tick(C);
  endtask

  task automatic test_back_to_back;
    int t0, t1;
    evq.delete();
    send_frame(8'h00, 1'b1, 1'b0, t0);
    send_frame(8'hFF, 1'b1, 1'b0, t1);
    tick(2);
    checks += 1;
    if (evq.size() != 2) begin
      errors++; $display("FAIL b2b_count: got %0d strobes want 2", evq.size());
    end else begin
      checks += 5;
      if (evq[0].kind != K_DV || evq[1].kind != K_DV) begin errors++; $display("FAIL b2b_kind: got %0d,%0d want 1,1", evq[0].kind, evq[1].kind); end
      if (evq[0].data !== 8'h00) begin errors++; $display("FAIL b2b_first: got %h want 00", evq[0].data); end
      if (evq[1].data !== 8'hFF) begin errors++; $display("FAIL b2b_second: got %h want ff", evq[1].data); end
      if (evq[0].cyc != t0 + LAT) begin errors++; $display("FAIL b2b_lat0: got %0d want %0d", evq[0].cyc - t0, LAT); end
      if (evq[1].cyc < t1 + LAT - 1 || evq[1].cyc > t1 + LAT + 1) begin
        errors++; $display("FAIL b2b_lat1: got %0d want %0d+-1", evq[1].cyc - t1, LAT);
      end
    end
    last_good = 8'hFF;
    tick(C);
  endtask

  task automatic test_reset_midframe;
    int t;
    logic [7:0] d;
    d = 8'h96;
    evq.delete();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rx = d[4];
    tick(C / 2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    rx    = 1'b1;
    checks += 5;
    if (data_out !== 8'h00)  begin errors++; $display("FAIL mid_reset_data: got %h want 00", data_out); end
    if (data_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_dv: got %b want 0", data_valid); end
    if (frame_err !== 1'b0)  begin errors++; $display("FAIL mid_reset_fe: got %b want 0", frame_err); end
    if (parity_err !== 1'b0) begin errors++; $display("FAIL mid_reset_pe: got %b want 0", parity_err); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
    tick(3 * C);
    checks += 1;
    if (evq.size() != 0) begin errors++; $display("FAIL mid_reset_strobes: got %0d want 0", evq.size()); end
    send_frame(8'h69, 1'b1, ^8'h69, t);
    tick(2);
    checks += 2;
    if (evq.size() != 1 || evq[0].kind != K_DV) begin
      errors++; $display("FAIL mid_reset_next: got %0d strobes want one data_valid", evq.size());
    end
    if (data_out !== 8'h69) begin errors++; $display("FAIL mid_reset_next_data: got %h want 69", data_out); end
    last_good = 8'h69;
    tick(C);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int t;
    evq.delete();
    send_frame(8'h81, 1'b1, 1'b1, t);
    tick(2);
    checks += 3;
    if (evq.size() != 1 || evq[0].kind != K_PE) begin
      errors++; $display("FAIL par_err_pulse: got %0d strobes want one parity_err", evq.size());
    end else if (evq[0].cyc != t + LAT) begin
      errors++; $display("FAIL par_err_latency: got %0d want %0d", evq[0].cyc - t, LAT);
    end
    if (data_out !== last_good) begin errors++; $display("FAIL par_err_hold: got %h want %h", data_out, last_good); end
    evq.delete();
    send_frame(8'h81, 1'b1, 1'b0, t);
    tick(2);
    if (evq.size() != 1 || evq[0].kind != K_DV || evq[0].data !== 8'h81) begin
      errors++; $display("FAIL par_ok: got %0d strobes data %h want one data_valid 81", evq.size(), data_out);
    end
    last_good = 8'h81;
    tick(C);
  endtask
`endif

  task automatic test_no_overlap;
    checks += 1;
    if (overlaps != 0) begin errors++; $display("FAIL strobe_overlap: got %0d want 0", overlaps); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    rx     = 1'b1;
    test_reset();
    test_good_frames(5);
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_good_frames(4);
    test_no_overlap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
